// File: rtl/gpioemu_pkg.sv
// Shared constants and type definitions for the gpioemu host-side sequencer.
package gpioemu_pkg;

  localparam logic [15:0] ADDR_A1   = 16'h0380;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;

  localparam logic [1:0] STATUS_DONE = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_A1,
    ST_WR_A2,
    ST_WR_GO,
    ST_POLL,
    ST_POLL_WAIT,
    ST_RD_W,
    ST_RD_L,
    ST_OUT
  } seq_state_t;

  typedef enum logic {
    ACC_WR = 1'b0,
    ACC_RD = 1'b1
  } acc_t;

  typedef enum logic [1:0] {
    XF_IDLE,
    XF_SETUP,
    XF_STROBE,
    XF_HOLD
  } xfer_state_t;

endpackage

// File: rtl/gpioemu_bus_xfer.sv
// Single register-bus access engine: SETUP, STROBE_CYCLES of strobe, HOLD.
// A request is taken only while idle; done flags the HOLD cycle.
module gpioemu_bus_xfer
  import gpioemu_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        i_req,
  input  logic        i_rnw,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_sdata_in,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [15:0] o_saddress,
  output logic        o_swr,
  output logic        o_srd,
  output logic [31:0] o_sdata_out
);

  xfer_state_t r_state;
  xfer_state_t w_next;
  acc_t        r_acc;
  logic [7:0]  r_cnt;
  logic [15:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_swr;
  logic        r_srd;
  logic        w_last;

  assign w_last = (r_cnt == 8'(STROBE_CYCLES - 1));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= XF_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      XF_IDLE:   if (i_req) w_next = XF_SETUP;
      XF_SETUP:  w_next = XF_STROBE;
      XF_STROBE: if (w_last) w_next = XF_HOLD;
      XF_HOLD:   w_next = XF_IDLE;
      default:   w_next = XF_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each access yields one clean pulse.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_acc   <= ACC_WR;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_swr   <= 1'b0;
      r_srd   <= 1'b0;
    end else begin
      if (r_state == XF_IDLE && i_req) begin
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_acc   <= i_rnw ? ACC_RD : ACC_WR;
      end
      if (r_state == XF_STROBE) r_cnt <= r_cnt + 8'd1;
      else                      r_cnt <= '0;
      r_swr <= (w_next == XF_STROBE) && (r_acc == ACC_WR);
      r_srd <= (w_next == XF_STROBE) && (r_acc == ACC_RD);
    end
  end

  assign o_done      = (r_state == XF_HOLD);
  assign o_rdata     = i_sdata_in;
  assign o_saddress  = r_addr;
  assign o_sdata_out = r_wdata;
  assign o_swr       = r_swr;
  assign o_srd       = r_srd;

endmodule

// File: rtl/gpioemu_host_seq.sv
// Host-side job sequencer: writes operands, kicks the peripheral, polls for
// completion, reads W and L back and offers the result on a valid/ready stream.
module gpioemu_host_seq
  import gpioemu_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned POLL_GAP      = 4,
  parameter int unsigned POLL_MAX      = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_a1,
  input  logic [23:0] job_a2,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_w,
  output logic [5:0]  res_ones,
  output logic [1:0]  res_status,
  output logic        res_err,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in,
  output logic [15:0] job_cnt
);

  seq_state_t  r_state;
  seq_state_t  w_next;
  logic [23:0] r_a1;
  logic [23:0] r_a2;
  logic [15:0] r_poll_cnt;
  logic [15:0] r_gap_cnt;
  logic        r_job_ready;
  logic        r_res_valid;
  logic [31:0] r_res_w;
  logic [5:0]  r_res_ones;
  logic [1:0]  r_res_status;
  logic        r_res_err;
  logic [15:0] r_job_cnt;

  logic        w_req;
  logic        w_rnw;
  logic [15:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_done;
  logic [31:0] w_rdata;
  logic        w_accept;
  logic        w_take;
  logic        w_poll_last;
  logic        w_gap_last;
  logic        w_stat_done;

  assign w_accept    = (r_state == ST_IDLE) && r_job_ready && job_valid;
  assign w_take      = (r_state == ST_OUT) && res_ready;
  assign w_poll_last = ((r_poll_cnt + 16'd1) == 16'(POLL_MAX));
  assign w_gap_last  = (r_gap_cnt == 16'(POLL_GAP - 1));
  assign w_stat_done = (w_rdata[1:0] == STATUS_DONE);

  gpioemu_bus_xfer #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_xfer (
    .clk        (clk),
    .n_reset    (n_reset),
    .i_req      (w_req),
    .i_rnw      (w_rnw),
    .i_addr     (w_addr),
    .i_wdata    (w_wdata),
    .i_sdata_in (sdata_in),
    .o_done     (w_done),
    .o_rdata    (w_rdata),
    .o_saddress (saddress),
    .o_swr      (swr),
    .o_srd      (srd),
    .o_sdata_out(sdata_out)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Request stays asserted for the whole access state; the engine ignores it once busy.
  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_rnw   = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_WR_A1;
      ST_WR_A1: begin
        w_req   = 1'b1;
        w_addr  = ADDR_A1;
        w_wdata = {8'h00, r_a1};
        if (w_done) w_next = ST_WR_A2;
      end
      ST_WR_A2: begin
        w_req   = 1'b1;
        w_addr  = ADDR_A2;
        w_wdata = {8'h00, r_a2};
        if (w_done) w_next = ST_WR_GO;
      end
      ST_WR_GO: begin
        w_req  = 1'b1;
        w_addr = ADDR_CTRL;
        if (w_done) w_next = ST_POLL;
      end
      ST_POLL: begin
        w_req  = 1'b1;
        w_rnw  = 1'b1;
        w_addr = ADDR_CTRL;
        if (w_done) begin
          if (w_stat_done)        w_next = ST_RD_W;
          else if (w_poll_last)   w_next = ST_OUT;
          else if (POLL_GAP == 0) w_next = ST_POLL;
          else                    w_next = ST_POLL_WAIT;
        end
      end
      ST_POLL_WAIT: if (w_gap_last) w_next = ST_POLL;
      ST_RD_W: begin
        w_req  = 1'b1;
        w_rnw  = 1'b1;
        w_addr = ADDR_W;
        if (w_done) w_next = ST_RD_L;
      end
      ST_RD_L: begin
        w_req  = 1'b1;
        w_rnw  = 1'b1;
        w_addr = ADDR_L;
        if (w_done) w_next = ST_OUT;
      end
      ST_OUT:  if (res_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_a1         <= '0;
      r_a2         <= '0;
      r_poll_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_job_ready  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_w      <= '0;
      r_res_ones   <= '0;
      r_res_status <= '0;
      r_res_err    <= 1'b0;
      r_job_cnt    <= '0;
    end else begin
      r_job_ready <= (w_next == ST_IDLE);
      r_res_valid <= (w_next == ST_OUT);
      if (w_accept) begin
        r_a1       <= job_a1;
        r_a2       <= job_a2;
        r_poll_cnt <= '0;
        r_res_err  <= 1'b0;
      end
      if (r_state == ST_POLL && w_done) begin
        r_res_status <= w_rdata[1:0];
        if (!w_stat_done) begin
          r_poll_cnt <= r_poll_cnt + 16'd1;
          if (w_poll_last) begin
            r_res_err  <= 1'b1;
            r_res_w    <= '0;
            r_res_ones <= '0;
          end
        end
      end
      if (r_state == ST_POLL_WAIT) r_gap_cnt <= r_gap_cnt + 16'd1;
      else                         r_gap_cnt <= '0;
      if (r_state == ST_RD_W && w_done) r_res_w <= w_rdata;
      if (r_state == ST_RD_L && w_done) r_res_ones <= w_rdata[5:0];
      if (w_take) r_job_cnt <= r_job_cnt + 16'd1;
    end
  end

  assign job_ready  = r_job_ready;
  assign res_valid  = r_res_valid;
  assign res_w      = r_res_w;
  assign res_ones   = r_res_ones;
  assign res_status = r_res_status;
  assign res_err    = r_res_err;
  assign job_cnt    = r_job_cnt;

endmodule

// File: tb/tb_gpioemu_host_seq.sv
// Randomized scoreboard bench for gpioemu_host_seq with a behavioural peripheral.
module tb_gpioemu_host_seq;

  localparam int SC = 3;
  localparam int PG = 4;
  localparam int PM = 4;

  localparam logic [15:0] A_A1   = 16'h0380;
  localparam logic [15:0] A_A2   = 16'h0388;
  localparam logic [15:0] A_W    = 16'h0390;
  localparam logic [15:0] A_L    = 16'h0398;
  localparam logic [15:0] A_CTRL = 16'h03A0;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  ones;
    logic [1:0]  st;
    logic        err;
    int          dly;
  } res_t;

  typedef struct {
    logic        rnw;
    logic [15:0] addr;
    logic [31:0] data;
  } bacc_t;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        job_valid = 1'b0;
  logic [23:0] job_a1 = '0;
  logic [23:0] job_a2 = '0;
  logic        res_ready = 1'b0;
  logic        job_ready;
  logic        res_valid;
  logic [31:0] res_w;
  logic [5:0]  res_ones;
  logic [1:0]  res_status;
  logic        res_err;
  logic [15:0] saddress;
  logic        swr;
  logic        srd;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in;
  logic [15:0] job_cnt;

  int    checks = 0;
  int    errors = 0;
  int    exp_cnt = 0;
  logic  busy = 1'b0;
  res_t  exp_q[$];
  bacc_t acc_q[$];

  always #5 clk = ~clk;

  gpioemu_host_seq #(
    .STROBE_CYCLES(SC),
    .POLL_GAP     (PG),
    .POLL_MAX     (PM)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_a1    (job_a1),
    .job_a2    (job_a2),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_w     (res_w),
    .res_ones  (res_ones),
    .res_status(res_status),
    .res_err   (res_err),
    .saddress  (saddress),
    .swr       (swr),
    .srd       (srd),
    .sdata_out (sdata_out),
    .sdata_in  (sdata_in),
    .job_cnt   (job_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Peripheral model: edge-triggered registers, status done after m_done_after polls.
  logic [23:0] m_a1 = '0;
  logic [23:0] m_a2 = '0;
  int          m_polls = 0;
  int          m_done_after = 0;
  logic [47:0] m_prod;

  always @(posedge swr) begin
    if (saddress == A_A1)        m_a1 = sdata_out[23:0];
    else if (saddress == A_A2)   m_a2 = sdata_out[23:0];
    else if (saddress == A_CTRL) m_polls = 0;
  end

  always @(posedge srd) begin
    if (saddress == A_CTRL) m_polls++;
  end

  always @* begin
    m_prod = {24'h0, m_a1} * {24'h0, m_a2};
    case (saddress)
      A_CTRL:  sdata_in = {30'h2AAAAAAA,
                           (m_done_after != 0 && m_polls >= m_done_after) ? 2'b11 : 2'b01};
      A_W:     sdata_in = m_prod[31:0];
      A_L:     sdata_in = {26'h2B5A3C1, 6'($countones(m_prod[31:0]))};
      default: sdata_in = 32'hDEADBEEF;
    endcase
  end

  // Bus monitor: access trace, strobe width, address stability, poll spacing.
  initial begin
    int          run = 0;
    int          lowrun = 0;
    logic        prev_s = 1'b0;
    logic        prev_poll = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [15:0] rise_addr = '0;
    bacc_t       e;
    forever begin
      @(negedge clk);
      if (!n_reset) begin
        chk("strobe_in_reset", {30'h0, swr, srd}, 32'h0);
        run = 0; lowrun = 0; prev_s = 1'b0; prev_poll = 1'b0;
        continue;
      end
      if (swr || srd) chk("swr_and_srd", 32'(swr && srd), 32'h0);
      if ((swr || srd) && !prev_s) begin
        chk("addr_setup", 32'(saddress), 32'(prev_addr));
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_access: got addr %0h rnw %0b expected none", saddress, srd);
        end else begin
          e = acc_q.pop_front();
          chk("acc_rnw", 32'(srd), 32'(e.rnw));
          chk("acc_addr", 32'(saddress), 32'(e.addr));
          if (!e.rnw) chk("acc_wdata", sdata_out, e.data);
        end
        if (srd && saddress == A_CTRL && prev_poll) chk("poll_gap", 32'(lowrun), 32'(PG + 3));
        prev_poll = srd && (saddress == A_CTRL);
        run = 1;
        rise_addr = saddress;
      end else if (swr || srd) begin
        run++;
        chk("addr_strobe", 32'(saddress), 32'(rise_addr));
      end else if (prev_s) begin
        chk("strobe_width", 32'(run), 32'(SC));
        chk("addr_hold", 32'(saddress), 32'(rise_addr));
        lowrun = 1;
      end else begin
        lowrun++;
      end
      prev_s = swr || srd;
      prev_addr = saddress;
    end
  end

  // Result monitor / consumer with per-job backpressure.
  initial begin
    logic        seen = 1'b0;
    logic        have = 1'b0;
    int          hold = 0;
    res_t        cur;
    logic [31:0] s_w = '0;
    logic [5:0]  s_ones = '0;
    logic [1:0]  s_st = '0;
    logic        s_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_reset) begin
        seen = 1'b0; res_ready = 1'b0;
        continue;
      end
      if (res_ready) begin
        res_ready = 1'b0;
        seen = 1'b0;
        chk("valid_after_take", 32'(res_valid), 32'h0);
        chk("ready_after_take", 32'(job_ready), 32'h1);
        chk("job_cnt", 32'(job_cnt), 32'(exp_cnt));
        busy = 1'b0;
        continue;
      end
      if (busy && !res_valid) chk("ready_low_busy", 32'(job_ready), 32'h0);
      if (res_valid) begin
        if (!seen) begin
          seen = 1'b1;
          have = (exp_q.size() != 0);
          if (have) cur = exp_q[0];
          else begin
            errors++;
            $display("FAIL unexpected_result: got w %0h expected no result", res_w);
          end
          hold = have ? cur.dly : 0;
          s_w = res_w; s_ones = res_ones; s_st = res_status; s_err = res_err;
        end else begin
          chk("bp_w_stable", res_w, s_w);
          chk("bp_ones_stable", 32'(res_ones), 32'(s_ones));
          chk("bp_status_stable", 32'(res_status), 32'(s_st));
          chk("bp_err_stable", 32'(res_err), 32'(s_err));
          chk("bp_ready_low", 32'(job_ready), 32'h0);
          chk("bp_no_strobe", 32'(swr || srd), 32'h0);
        end
        if (hold == 0) begin
          if (have) begin
            chk("res_w", res_w, cur.w);
            chk("res_ones", 32'(res_ones), 32'(cur.ones));
            chk("res_status", 32'(res_status), 32'(cur.st));
            chk("res_err", 32'(res_err), 32'(cur.err));
            void'(exp_q.pop_front());
          end
          exp_cnt = (exp_cnt + 1) & 16'hFFFF;
          res_ready = 1'b1;
        end else begin
          hold--;
        end
      end
    end
  end

  task automatic push_acc(input logic rnw, input logic [15:0] addr, input logic [31:0] data);
    bacc_t e;
    e.rnw = rnw; e.addr = addr; e.data = data;
    acc_q.push_back(e);
  endtask

  // Issue one job; k = poll on which status reads done (0 = never).
  task automatic run_job(input logic [23:0] a1, input logic [23:0] a2, input int k, input int dly);
    int          t = 0;
    int          npoll;
    logic        ok;
    logic [47:0] p;
    res_t        r;
    while (!job_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!job_ready) begin
      errors++;
      $display("FAIL job_ready_timeout: got 0 expected 1 within 2000 cycles");
      finish_sim();
    end
    ok    = (k >= 1 && k <= PM);
    npoll = ok ? k : PM;
    p     = {24'h0, a1} * {24'h0, a2};
    r.w    = ok ? p[31:0] : 32'h0;
    r.ones = ok ? 6'($countones(p[31:0])) : 6'h0;
    r.st   = ok ? 2'b11 : 2'b01;
    r.err  = !ok;
    r.dly  = dly;
    exp_q.push_back(r);
    push_acc(1'b0, A_A1, {8'h0, a1});
    push_acc(1'b0, A_A2, {8'h0, a2});
    push_acc(1'b0, A_CTRL, 32'h0);
    for (int i = 0; i < npoll; i++) push_acc(1'b1, A_CTRL, 32'h0);
    if (ok) begin
      push_acc(1'b1, A_W, 32'h0);
      push_acc(1'b1, A_L, 32'h0);
    end
    m_done_after = k;
    job_a1 = a1;
    job_a2 = a2;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    job_a1 = 24'($urandom());
    job_a2 = 24'($urandom());
    busy = 1'b1;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_results_left", 32'(exp_q.size()), 32'h0);
    chk("drain_access_left", 32'(acc_q.size()), 32'h0);
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk("rst_job_ready", 32'(job_ready), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_job_cnt", 32'(job_cnt), 32'h0);
    chk("rst_saddress", 32'(saddress), 32'h0);
    #2 n_reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(job_ready), 32'h1);
    chk("res_w_after_rst", res_w, 32'h0);

    run_job(24'd3, 24'd5, 2, 0);
    run_job(24'hFFFFFF, 24'hFFFFFF, 1, 10);
    run_job(24'd2, 24'd3, 3, 1);
    run_job(24'h00ABCD, 24'h001234, 0, 2);
    run_job(24'h123456, 24'h000010, PM, 0);
    run_job(24'h000077, 24'h000099, PM + 1, 3);
    for (int i = 0; i < 12; i++) begin
      run_job(24'($urandom()), 24'($urandom()), int'($urandom_range(1, 6)),
              int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    run_job(24'h000123, 24'h000456, 2, 0);
    t = 0;
    while (!(swr && saddress == A_A2) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("saw_wr_a2_strobe", 32'(swr && saddress == A_A2), 32'h1);
    #1 n_reset = 1'b0;
    #1;
    chk("mid_rst_swr", 32'(swr), 32'h0);
    chk("mid_rst_srd", 32'(srd), 32'h0);
    chk("mid_rst_saddress", 32'(saddress), 32'h0);
    chk("mid_rst_sdata_out", sdata_out, 32'h0);
    chk("mid_rst_job_ready", 32'(job_ready), 32'h0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'h0);
    chk("mid_rst_res_w", res_w, 32'h0);
    chk("mid_rst_res_ones", 32'(res_ones), 32'h0);
    chk("mid_rst_res_status", 32'(res_status), 32'h0);
    chk("mid_rst_res_err", 32'(res_err), 32'h0);
    chk("mid_rst_job_cnt", 32'(job_cnt), 32'h0);
    exp_q.delete();
    acc_q.delete();
    busy = 1'b0;
    exp_cnt = 0;
    repeat (3) @(negedge clk);
    #2 n_reset = 1'b1;
    @(negedge clk);
    run_job(24'd7, 24'd9, 1, 2);
    drain();
    chk("final_job_cnt", 32'(job_cnt), 32'h1);
    finish_sim();
  end

endmodule
